logic_unit_pipe: RTL and testbench

- Parametrised, registered successor to the team's single-bit AND primitive.
- Applies one of eight bitwise operations to two WIDTH-bit operands per transaction:
  - six two-input gates;
  - two accumulating modes that fold A into a running AND / OR register.
- Valid/ready handshake on both sides, 2-entry output buffer, result flags and a transaction counter.
- Sits between a stimulus/sequencer source and any downstream consumer needing gate-level logic results on wide buses.

---
 rtl/logic_pkg.sv | 33 +++
 rtl/result_fifo2.sv | 60 ++++++
 rtl/logic_unit_pipe.sv | 106 ++++++++++
 tb/tb_logic_unit_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// logic_pkg: shared opcodes and gate helper for logic_unit_pipe.
// Gate helper works per bit so any operand width can reuse it.
package logic_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XNOR    = 3'd5;
  localparam logic [2:0] OP_ACC_AND = 3'd6;
  localparam logic [2:0] OP_ACC_OR  = 3'd7;

  function automatic logic gate_bit(
    input logic [2:0] op,
    input logic       a,
    input logic       b
  );
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/result_fifo2.sv
// result_fifo2: two-entry synchronous FIFO for result bundles.
// Head data is registered storage, so it stays stable until popped.
module result_fifo2 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // occupancy after this cycle's push/pop
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise unit with accumulators,
// valid/ready handshake, 2-deep result buffer and txn counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_zero,
  output logic             res_ones,
  output logic [CNT_W-1:0] txn_count
);

  import logic_pkg::*;

  localparam int FW = WIDTH + 2;

  logic [WIDTH-1:0] acc_and_q;
  logic [WIDTH-1:0] acc_and_d;
  logic [WIDTH-1:0] acc_or_q;
  logic [WIDTH-1:0] acc_or_d;
  logic [WIDTH-1:0] and_base;
  logic [WIDTH-1:0] or_base;
  logic [WIDTH-1:0] res_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             full;
  logic             empty;
  logic [FW-1:0]    head;
  logic [FW-1:0]    entry;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign accept    = in_valid & in_ready;
  assign txn_count = cnt_q;
  assign {result, res_zero, res_ones} = head;

  // a same-cycle clear takes effect before the fold
  assign and_base = acc_clr ? '1 : acc_and_q;
  assign or_base  = acc_clr ? '0 : acc_or_q;

  // result of the presented operation
  always_comb begin
    res_d = '0;
    unique case (1'b1)
      (op == OP_ACC_AND): res_d = and_base & a;
      (op == OP_ACC_OR):  res_d = or_base | a;
      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          res_d[i] = gate_bit(op, a[i], b[i]);
        end
      end
    endcase
  end

  assign entry = {res_d, (res_d == '0), (&res_d)};

  // accumulator and counter next state
  always_comb begin
    acc_and_d = and_base;
    acc_or_d  = or_base;
    cnt_d     = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (op == OP_ACC_AND) acc_and_d = res_d;
      if (op == OP_ACC_OR)  acc_or_d  = res_d;
    end
  end

  // accumulator and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_and_q <= '1;
      acc_or_q  <= '0;
      cnt_q     <= '0;
    end else begin
      acc_and_q <= acc_and_d;
      acc_or_q  <= acc_or_d;
      cnt_q     <= cnt_d;
    end
  end

  result_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (out_valid & out_ready),
    .data_i  (entry),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed vectors plus a queue-based model
// compared against the DUT on every falling edge.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       res_zero;
  logic       res_ones;
  logic [3:0] txn_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic_unit_pipe #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .res_zero  (res_zero),
    .res_ones  (res_ones),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference model: queue of pending results, plain accumulators
  logic [7:0] mq[$];
  logic [7:0] m_and;
  logic [7:0] m_or;
  logic [3:0] m_cnt;
  logic [7:0] m_r;
  bit         m_acc;
  bit         m_con;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_and = 8'hFF;
      m_or  = 8'h00;
      m_cnt = 4'd0;
    end else begin
      m_acc = in_valid && (mq.size() < 2);
      m_con = out_ready && (mq.size() > 0);
      if (acc_clr) begin
        m_and = 8'hFF;
        m_or  = 8'h00;
      end
      m_r = 8'h00;
      if (m_acc) begin
        case (op)
          3'd0: m_r = a & b;
          3'd1: m_r = a | b;
          3'd2: m_r = a ^ b;
          3'd3: m_r = ~(a & b);
          3'd4: m_r = ~(a | b);
          3'd5: m_r = ~(a ^ b);
          3'd6: begin m_and = m_and & a; m_r = m_and; end
          default: begin m_or = m_or | a; m_r = m_or; end
        endcase
        m_cnt = m_cnt + 4'd1;
      end
      if (m_con) void'(mq.pop_front());
      if (m_acc) mq.push_back(m_r);
    end
  end

  // compare DUT to model away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_txn_count", 32'(txn_count), 32'(0));
    end else begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("txn_count", 32'(txn_count), 32'(m_cnt));
      if (mq.size() != 0) begin
        chk("head", 32'(result), 32'(mq[0]));
        chk("head_zero", 32'(res_zero), 32'(mq[0] == 8'h00));
        chk("head_ones", 32'(res_ones), 32'(mq[0] == 8'hFF));
      end
    end
  end

  // present one transaction; its result is head one cycle later
  task automatic xact(input logic [2:0] o, input logic [7:0] av,
                      input logic [7:0] bv, input logic [7:0] exp);
    in_valid = 1'b1;
    op = o;
    a  = av;
    b  = bv;
    @(posedge clk);
    #1;
    chk("x_valid", 32'(out_valid), 32'(1));
    chk("x_result", 32'(result), 32'(exp));
    chk("x_zero", 32'(res_zero), 32'(exp == 8'h00));
    chk("x_ones", 32'(res_ones), 32'(exp == 8'hFF));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op = 3'd0;
    a  = 8'h00;
    b  = 8'h00;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = 3'd0;
    a = 8'h00;
    b = 8'h00;
    acc_clr = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_result", 32'(result), 32'(0));
    chk("reset_zero", 32'(res_zero), 32'(0));
    chk("reset_ones", 32'(res_ones), 32'(0));
    chk("reset_count", 32'(txn_count), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'(1));

    // six gates back to back
    xact(3'd0, 8'hF0, 8'h3C, 8'h30);
    xact(3'd1, 8'hF0, 8'h3C, 8'hFC);
    xact(3'd2, 8'hF0, 8'h3C, 8'hCC);
    xact(3'd3, 8'hF0, 8'h3C, 8'hCF);
    xact(3'd4, 8'hF0, 8'h3C, 8'h03);
    xact(3'd5, 8'hF0, 8'h3C, 8'h33);
    idle();
    chk("count_after_gates", 32'(txn_count), 32'(6));

    // flags
    xact(3'd0, 8'h00, 8'hFF, 8'h00);
    xact(3'd1, 8'h00, 8'hFF, 8'hFF);
    idle();

    // accumulate
    xact(3'd6, 8'hF7, 8'h00, 8'hF7);
    xact(3'd6, 8'h7F, 8'h00, 8'h77);
    xact(3'd6, 8'hFE, 8'h00, 8'h76);
    idle();
    acc_clr = 1'b1;
    idle();
    acc_clr = 1'b0;
    xact(3'd7, 8'h01, 8'h00, 8'h01);
    xact(3'd7, 8'h80, 8'h00, 8'h81);
    idle();

    // clear together with an accepted ACC_AND
    xact(3'd6, 8'h00, 8'h00, 8'h00);
    acc_clr = 1'b1;
    xact(3'd6, 8'h0F, 8'h00, 8'h0F);
    acc_clr = 1'b0;
    idle();

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd1;
    a = 8'h11;
    b = 8'h22;
    @(posedge clk);
    #1;
    a = 8'h44;
    b = 8'h00;
    @(posedge clk);
    #1;
    chk("bp_full_ready", 32'(in_ready), 32'(0));
    a = 8'h0F;
    b = 8'hF0;
    @(posedge clk);
    #1;
    chk("bp_head_hold1", 32'(result), 32'(8'h33));
    chk("bp_ready_hold", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    chk("bp_head_hold2", 32'(result), 32'(8'h33));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drain_2nd", 32'(result), 32'(8'h44));
    chk("bp_ready_again", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_drain_3rd", 32'(result), 32'(8'hFF));
    @(posedge clk);
    #1;
    chk("bp_empty", 32'(out_valid), 32'(0));

    // counter wrap with CNT_W=4
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      xact(3'd0, 8'hFF, 8'(i), 8'(i));
    end
    idle();
    chk("count_wrap", 32'(txn_count), 32'(1));

    // reset with two buffered entries
    xact(3'd6, 8'h00, 8'h00, 8'h00);
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = 3'd0;
    a = 8'hAA;
    b = 8'hFF;
    @(posedge clk);
    #1;
    a = 8'h55;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'(1));
    chk("pre_rst_full", 32'(in_ready), 32'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_count", 32'(txn_count), 32'(0));
    chk("mid_rst_result", 32'(result), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    xact(3'd6, 8'h5A, 8'h00, 8'h5A);
    idle();
    chk("post_rst_count", 32'(txn_count), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
